// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader and its byte receiver.
package boot_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        WORD,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_boot_loader_rx_byte.sv
// 8N1 UART byte receiver: synchronizes rx, mid-bit samples, flags bad stop bits.
module uart_rx_byte
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (rx_prev && !rx_sync)
                        state <= RX_START;
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        state    <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        rx_byte  <= {rx_sync, rx_byte[7:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= RX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        rx_valid <= rx_sync;
                        rx_ferr  <= !rx_sync;
                        state    <= RX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: receives a length-prefixed image over UART and writes it
// into instruction memory, holding the core in reset until the image is complete.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 10,
    parameter int MAX_WORDS    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0]  LAST_LANE = 2'(BYTES_PER_WORD - 1);
    localparam logic [16:0] MAX_N     = 17'(MAX_WORDS);

    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          rx_ferr;

    loader_state_t state;
    logic [15:0]   img_words;
    logic [15:0]   word_cnt;
    logic [1:0]    byte_idx;
    logic [23:0]   word_sr;
    logic [15:0]   hdr_n;

    assign hdr_n = {rx_byte, img_words[7:0]};

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .rx_ferr (rx_ferr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            img_words  <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            word_sr    <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (imem_we) begin
                imem_waddr <= imem_waddr + ADDR_W'(1);
                word_cnt   <= word_cnt + 16'd1;
            end
            case (state)
                IDLE, HDR_LO: begin
                    if (rx_ferr) begin
                        state <= ERROR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (rx_valid) begin
                        img_words[7:0] <= rx_byte;
                        busy           <= 1'b1;
                        state          <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (rx_ferr) begin
                        state <= ERROR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (rx_valid) begin
                        img_words <= hdr_n;
                        if (hdr_n == 16'd0) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            core_reset <= 1'b0;
                        end else if ({1'b0, hdr_n} > MAX_N) begin
                            state <= ERROR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state      <= WORD;
                            byte_idx   <= '0;
                            word_cnt   <= '0;
                            imem_waddr <= '0;
                        end
                    end
                end
                WORD: begin
                    // Completion is decided one cycle after the final strobe so that
                    // core_reset and done change together right after the last write.
                    if (imem_we && (word_cnt == img_words - 16'd1)) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        core_reset <= 1'b0;
                    end else if (rx_ferr) begin
                        state <= ERROR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (rx_valid) begin
                        case (byte_idx)
                            2'd0:    word_sr[7:0]   <= rx_byte;
                            2'd1:    word_sr[15:8]  <= rx_byte;
                            2'd2:    word_sr[23:16] <= rx_byte;
                            default: word_sr        <= word_sr;
                        endcase
                        if (byte_idx == LAST_LANE) begin
                            imem_wdata <= {rx_byte, word_sr};
                            imem_we    <= 1'b1;
                        end
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                DONE, ERROR: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed self-checking bench for uart_boot_loader with CLKS_PER_BIT = 8, MAX_WORDS = 16.
module tb_uart_boot_loader;
    import boot_pkg::*;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;

    uart_boot_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (10),
        .MAX_WORDS   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Write monitor: logs every strobe and the cycle at which done rises.
    int          cycle = 0;
    int          we_n = 0;
    logic [9:0]  we_addr [64];
    logic [31:0] we_data [64];
    int          we_cyc  [64];
    int          rxv_n = 0;
    logic        done_prev = 1'b0;
    int          done_cyc = -1;
    logic        done_core_reset = 1'b1;
    logic        done_busy = 1'b1;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (imem_we && we_n < 64) begin
            we_addr[we_n] = imem_waddr;
            we_data[we_n] = imem_wdata;
            we_cyc[we_n]  = cycle;
        end
        if (imem_we) we_n = we_n + 1;
        if (dut.u_rx.rx_valid) rxv_n = rxv_n + 1;
        if (done && !done_prev) begin
            done_cyc        = cycle;
            done_core_reset = core_reset;
            done_busy       = busy;
        end
        done_prev = done;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] bytes [], input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[i], 1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run += 8;
        if (imem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_we: got %b expected 0", imem_we); end
        if (imem_waddr !== 10'd0) begin tests_failed++; $display("[TB] FAIL reset_waddr: got %h expected 0", imem_waddr); end
        if (imem_wdata !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_wdata: got %h expected 0", imem_wdata); end
        if (core_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_core_reset: got %b expected 1", core_reset); end
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        if (dut.state !== IDLE) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected IDLE", dut.state); end
    endtask

    task automatic test_two_word();
        int base;
        logic [7:0] img [] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        do_reset();
        base = we_n;
        send_byte(8'h02, 1'b1);
        repeat (10) @(negedge clk);
        tests_run += 2;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL two_word_busy_after_hdr: got %b expected 1", busy); end
        if (core_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL two_word_core_reset_loading: got %b expected 1", core_reset); end
        send_byte(8'h00, 1'b1);
        applyStimulus(img, 8);
        tests_run += 1;
        if (we_n - base !== 2) begin
            tests_failed++; $display("[TB] FAIL two_word_count: got %0d expected 2", we_n - base);
        end else begin
            tests_run += 6;
            if (we_addr[base] !== 10'd0) begin tests_failed++; $display("[TB] FAIL two_word_addr0: got %h expected 000", we_addr[base]); end
            if (we_data[base] !== 32'h00000513) begin tests_failed++; $display("[TB] FAIL two_word_data0: got %h expected 00000513", we_data[base]); end
            if (we_addr[base+1] !== 10'd1) begin tests_failed++; $display("[TB] FAIL two_word_addr1: got %h expected 001", we_addr[base+1]); end
            if (we_data[base+1] !== 32'h00100593) begin tests_failed++; $display("[TB] FAIL two_word_data1: got %h expected 00100593", we_data[base+1]); end
            if (done_cyc !== we_cyc[base+1] + 1) begin tests_failed++; $display("[TB] FAIL two_word_done_timing: got cycle %0d expected %0d", done_cyc, we_cyc[base+1] + 1); end
            if (done_core_reset !== 1'b0 || done_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL two_word_release: got core_reset=%b busy=%b expected 0/0", done_core_reset, done_busy); end
        end
        tests_run += 2;
        if (done !== 1'b1 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL two_word_done: got done=%b err=%b expected 1/0", done, err); end
        if (imem_waddr !== 10'd2) begin tests_failed++; $display("[TB] FAIL two_word_final_addr: got %h expected 002", imem_waddr); end
    endtask

    task automatic test_zero_words();
        int base;
        logic [7:0] img [] = '{8'h00, 8'h00};
        do_reset();
        base = we_n;
        applyStimulus(img, 2);
        tests_run += 3;
        if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_done: got done=%b busy=%b expected 1/0", done, busy); end
        if (core_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_core_reset: got %b expected 0", core_reset); end
        if (we_n !== base) begin tests_failed++; $display("[TB] FAIL zero_no_write: got %0d writes expected 0", we_n - base); end
    endtask

    task automatic test_oversize();
        int base;
        logic [7:0] hdr [] = '{8'h11, 8'h00};
        logic [7:0] img [] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        do_reset();
        base = we_n;
        applyStimulus(hdr, 2);
        tests_run += 2;
        if (err !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL oversize_err: got err=%b busy=%b expected 1/0", err, busy); end
        if (core_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL oversize_core_reset: got %b expected 1", core_reset); end
        applyStimulus(img, 6);
        tests_run += 2;
        if (we_n !== base) begin tests_failed++; $display("[TB] FAIL oversize_ignored: got %0d writes expected 0", we_n - base); end
        if (done !== 1'b0 || err !== 1'b1) begin tests_failed++; $display("[TB] FAIL oversize_sticky: got done=%b err=%b expected 0/1", done, err); end
    endtask

    task automatic test_framing();
        int base;
        logic [7:0] img [] = '{8'h01, 8'h00, 8'h11, 8'h22};
        do_reset();
        base = we_n;
        applyStimulus(img, 4);
        send_byte(8'h33, 1'b0);
        repeat (20) @(negedge clk);
        tests_run += 3;
        if (err !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL framing_err: got err=%b done=%b expected 1/0", err, done); end
        if (we_n !== base) begin tests_failed++; $display("[TB] FAIL framing_no_write: got %0d writes expected 0", we_n - base); end
        if (core_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL framing_core_reset: got %b expected 1", core_reset); end
    endtask

    task automatic test_glitch();
        int base;
        do_reset();
        base = rxv_n;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        tests_run += 3;
        if (rxv_n !== base) begin tests_failed++; $display("[TB] FAIL glitch_rx_valid: got %0d bytes expected 0", rxv_n - base); end
        if (dut.state !== IDLE) begin tests_failed++; $display("[TB] FAIL glitch_state: got %0d expected IDLE", dut.state); end
        if (busy !== 1'b0 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL glitch_flags: got busy=%b err=%b expected 0/0", busy, err); end
    endtask

    task automatic test_reset_mid_image();
        int base;
        logic [7:0] part [] = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        logic [7:0] img  [] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        base = we_n;
        applyStimulus(part, 5);
        do_reset();
        tests_run += 3;
        if (we_n !== base) begin tests_failed++; $display("[TB] FAIL midreset_no_write: got %0d writes expected 0", we_n - base); end
        if (imem_we !== 1'b0 || imem_waddr !== 10'd0 || imem_wdata !== 32'd0) begin
            tests_failed++; $display("[TB] FAIL midreset_outputs: got we=%b addr=%h data=%h expected 0/000/00000000", imem_we, imem_waddr, imem_wdata);
        end
        if (core_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL midreset_status: got core_reset=%b busy=%b done=%b err=%b expected 1/0/0/0", core_reset, busy, done, err);
        end
        base = we_n;
        applyStimulus(img, 6);
        tests_run += 2;
        if (we_n - base !== 1) begin
            tests_failed++; $display("[TB] FAIL midreset_fresh_count: got %0d expected 1", we_n - base);
        end else if (we_addr[base] !== 10'd0 || we_data[base] !== 32'hDEADBEEF) begin
            tests_failed++; $display("[TB] FAIL midreset_fresh_write: got addr=%h data=%h expected 000/deadbeef", we_addr[base], we_data[base]);
        end
        if (done !== 1'b1 || core_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_fresh_done: got done=%b core_reset=%b expected 1/0", done, core_reset); end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_zero_words();
        test_oversize();
        test_framing();
        test_glitch();
        test_reset_mid_image();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
